// File: rtl/ip4_sm_rd.sv
// ip4_sm_rd: read sequencer for one ip4 shared-memory bank; the writer has priority and returned words are buffered in a first-word-fall-through FIFO
module ip4_sm_rd #(
  parameter int ADR_W = 10,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [ADR_W-1:0] req_adr,
  input  logic [3:0]       req_len,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             wr_busy,
  output logic             bk_rd,
  output logic [ADR_W-1:0] bk_adr,
  input  logic [31:0]      bk_datao,
  output logic             rsp_vld,
  input  logic             rsp_rdy,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_last,
  output logic             busy
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = DEPTH[PW:0];
  typedef enum logic {IDLE, BURST} st_t;
  st_t st, st_n;
  logic [ADR_W-1:0] cur_adr;
  logic [3:0]       rem;
  logic [TAG_W-1:0] tag, if_tag;
  logic             inflight, if_last;
  logic [31:0]      m_data [DEPTH];
  logic [TAG_W-1:0] m_tag [DEPTH];
  logic             m_last [DEPTH];
  logic [PW-1:0]    wp, rp;
  logic [PW:0]      cnt;
  logic             issue, pop;
  // a read is only issued when the FIFO has room for it counting the word still in flight
  always_comb begin
    issue    = (st == BURST) & !wr_busy & ((cnt + (PW+1)'(inflight)) < FULL);
    st_n     = (st == IDLE) ? (req_vld ? BURST : IDLE) : ((issue && rem == 4'd0) ? IDLE : BURST);
    req_rdy  = (st == IDLE);
    bk_rd    = issue;
    bk_adr   = issue ? cur_adr : '0;
    rsp_vld  = (cnt != '0);
    pop      = rsp_vld & rsp_rdy;
    rsp_data = rsp_vld ? m_data[rp] : '0;
    rsp_tag  = rsp_vld ? m_tag[rp] : '0;
    rsp_last = rsp_vld & m_last[rp];
    busy     = (st == BURST) | inflight | rsp_vld;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      cur_adr  <= '0;
      rem      <= '0;
      tag      <= '0;
      inflight <= 1'b0;
      if_tag   <= '0;
      if_last  <= 1'b0;
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
    end else begin
      st <= st_n;
      if (st == IDLE && req_vld) begin
        cur_adr <= req_adr;
        rem     <= req_len;
        tag     <= req_tag;
      end else if (issue) begin
        cur_adr <= cur_adr + ADR_W'(1);
        rem     <= rem - 4'd1;
      end
      inflight <= issue;
      if (issue) begin
        if_tag  <= tag;
        if_last <= (rem == 4'd0);
      end
      if (inflight) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      cnt <= cnt + (PW+1)'(inflight) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (inflight) begin
      m_data[wp] <= bk_datao;
      m_tag[wp]  <= if_tag;
      m_last[wp] <= if_last;
    end
  end
endmodule

// File: tb/tb_ip4_sm_rd.sv
// tb_ip4_sm_rd: directed checks of ip4_sm_rd against a 1-cycle-latency bank model
module tb_ip4_sm_rd;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_vld = 1'b0, req_rdy;
  logic [9:0]  req_adr = '0;
  logic [3:0]  req_len = '0;
  logic [3:0]  req_tag = '0;
  logic        wr_busy = 1'b0, bk_rd;
  logic [9:0]  bk_adr;
  logic [31:0] bk_datao = '0;
  logic        rsp_vld, rsp_rdy = 1'b1, rsp_last, busy;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic [31:0] bank [1024];
  int total = 0, bad = 0, cyc = 0, acc = 0, nis = 0, npop = 0, fall_cyc = -1, rise_cyc = -1;
  logic pbusy = 1'b0, prdy = 1'b1;
  int iss_adr [$], iss_cyc [$], r_cyc [$];
  logic [31:0] r_data [$];
  logic [3:0] r_tag [$];
  logic r_last [$];

  ip4_sm_rd dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy), .req_adr(req_adr),
    .req_len(req_len), .req_tag(req_tag), .wr_busy(wr_busy), .bk_rd(bk_rd), .bk_adr(bk_adr),
    .bk_datao(bk_datao), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_last(rsp_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bk_rd) bk_datao <= bank[bk_adr];

  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", t, obs, exp, cyc);
    end
  endtask

  // observe issues, pops and edges at the falling clock edge
  always @(negedge clk) begin
    if (!rst_n) begin
      nis = 0;
      npop = 0;
    end else begin
      if (bk_rd) begin
        chk("wr_prio", {31'd0, wr_busy}, 0);
        chk("credit", {31'd0, (nis - npop) < 4}, 1);
        iss_adr.push_back(int'(bk_adr));
        iss_cyc.push_back(cyc);
        nis++;
      end
      if (rsp_vld && rsp_rdy) begin
        r_data.push_back(rsp_data);
        r_tag.push_back(rsp_tag);
        r_last.push_back(rsp_last);
        r_cyc.push_back(cyc);
        npop++;
      end
    end
    if (pbusy && !busy) fall_cyc = cyc;
    if (!prdy && req_rdy) rise_cyc = cyc;
    pbusy = busy;
    prdy = req_rdy;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    iss_adr.delete(); iss_cyc.delete(); r_cyc.delete();
    r_data.delete(); r_tag.delete(); r_last.delete();
  endtask

  task automatic req(input logic [9:0] a, input logic [3:0] l, input logic [3:0] t);
    chk("req_rdy_pre", {31'd0, req_rdy}, 1);
    req_vld = 1'b1; req_adr = a; req_len = l; req_tag = t;
    step();
    acc = cyc;
    req_vld = 1'b0;
  endtask

  task automatic wait_idle(input int mx);
    int n = 0;
    while (busy && n < mx) begin
      step();
      n++;
    end
    chk("idle_tmo", {31'd0, busy}, 0);
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) bank[i] = i;
    bank[10'h010] = 32'hDEADBEEF;
    bank[10'h100] = 32'hCAFE0100;
    #12;
    chk("rst_req_rdy", {31'd0, req_rdy}, 1);
    chk("rst_bk_rd", {31'd0, bk_rd}, 0);
    chk("rst_rsp_vld", {31'd0, rsp_vld}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    step(2);
    rst_n = 1'b1;
    step(2);

    // single read
    clr();
    req(10'h010, 4'd0, 4'd5);
    wait_idle(50);
    chk("s_niss", iss_adr.size(), 1);
    chk("s_adr", iss_adr[0], 32'h010);
    chk("s_iss_cyc", iss_cyc[0], acc);
    chk("s_nrsp", r_data.size(), 1);
    chk("s_data", r_data[0], 32'hDEADBEEF);
    chk("s_tag", {28'd0, r_tag[0]}, 5);
    chk("s_last", {31'd0, r_last[0]}, 1);
    chk("s_rsp_cyc", r_cyc[0], acc + 2);
    chk("s_busy_fall", fall_cyc, acc + 3);
    chk("s_rdy_rise", rise_cyc, acc + 1);

    // burst wrapping the top of the bank
    clr();
    req(10'h3FE, 4'd3, 4'd2);
    wait_idle(50);
    chk("w_niss", iss_adr.size(), 4);
    chk("w_nrsp", r_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("w_adr", iss_adr[i], (32'h3FE + i) & 32'h3FF);
      chk("w_cyc", iss_cyc[i], acc + i);
      chk("w_data", r_data[i], (32'h3FE + i) & 32'h3FF);
      chk("w_tag", {28'd0, r_tag[i]}, 2);
      chk("w_last", {31'd0, r_last[i]}, (i == 3) ? 1 : 0);
    end
    chk("w_rdy_rise", rise_cyc, acc + 4);

    // writer priority during burst cycles 2-4
    clr();
    req(10'h050, 4'd7, 4'd7);
    step();
    wr_busy = 1'b1;
    step(3);
    wr_busy = 1'b0;
    wait_idle(50);
    chk("p_niss", iss_adr.size(), 8);
    chk("p_resume_cyc", iss_cyc[1], acc + 4);
    chk("p_nrsp", r_data.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("p_adr", iss_adr[i], 32'h050 + i);
      chk("p_data", r_data[i], 32'h050 + i);
      chk("p_last", {31'd0, r_last[i]}, (i == 7) ? 1 : 0);
    end

    // backpressure, credit stall and single-cycle pops on a full FIFO
    clr();
    rsp_rdy = 1'b0;
    req(10'h200, 4'd15, 4'd9);
    step(12);
    chk("b_niss", iss_adr.size(), 4);
    chk("b_vld", {31'd0, rsp_vld}, 1);
    chk("b_head", rsp_data, 32'h200);
    step(3);
    chk("b_head_hold", rsp_data, 32'h200);
    chk("b_tag_hold", {28'd0, rsp_tag}, 9);
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;
    step(4);
    chk("f_niss1", iss_adr.size(), 5);
    chk("f_head1", rsp_data, 32'h201);
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;
    step(4);
    chk("f_niss2", iss_adr.size(), 6);
    chk("f_head2", rsp_data, 32'h202);
    rsp_rdy = 1'b1;
    wait_idle(100);
    chk("b_nrsp", r_data.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("b_data", r_data[i], 32'h200 + i);
      chk("b_last", {31'd0, r_last[i]}, (i == 15) ? 1 : 0);
    end

    // reset in the middle of a burst
    clr();
    req(10'h300, 4'd7, 4'd3);
    step(2);
    rst_n = 1'b0;
    #1;
    chk("r_req_rdy", {31'd0, req_rdy}, 1);
    chk("r_bk_rd", {31'd0, bk_rd}, 0);
    chk("r_bk_adr", {22'd0, bk_adr}, 0);
    chk("r_rsp_vld", {31'd0, rsp_vld}, 0);
    chk("r_rsp_data", rsp_data, 0);
    chk("r_busy", {31'd0, busy}, 0);
    step(2);
    rst_n = 1'b1;
    step();
    clr();
    req(10'h100, 4'd0, 4'd1);
    wait_idle(50);
    chk("r_nrsp", r_data.size(), 1);
    chk("r_data", r_data[0], 32'hCAFE0100);
    chk("r_tag", {28'd0, r_tag[0]}, 1);
    chk("r_last", {31'd0, r_last[0]}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
